// File: rtl/data_mem_pkg.sv
// Shared encodings for the data-memory stage: access sizes, FSM states and lane widths.
// Imported by the controller top and its lane helper.
package data_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_ILL  = 2'd3;

   localparam int BYTE_W  = 8;
   localparam int HALF_W  = 16;
   localparam int WORD_W  = 32;
   localparam int N_LANES = WORD_W / BYTE_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      return ((size == SZ_HALF) && addr_lo[0]) || ((size == SZ_WORD) && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/dmem_lane.sv
// Combinational lane logic: extracts and extends byte/half loads from a memory word,
// merges byte/half/word store data into the selected lanes, and flags misalignment.
module dmem_lane
   import data_mem_pkg::*;
(
   input  logic [1:0]  addr_lo_i,
   input  logic [1:0]  size_i,
   input  logic        uns_i,
   input  logic [31:0] word_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merge_o,
   output logic        misalign_o
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [3:0]  byte_en;

   assign misalign_o = misaligned(size_i, addr_lo_i);
   assign lane_byte  = word_i[{addr_lo_i, 3'b000} +: BYTE_W];
   assign lane_half  = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

   always_comb begin
      load_o = word_i;
      case (size_i)
         SZ_BYTE: load_o = uns_i ? {24'd0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
         SZ_HALF: load_o = uns_i ? {16'd0, lane_half} : {{16{lane_half[15]}}, lane_half};
         default: load_o = word_i;
      endcase
   end

   always_comb begin
      byte_en = 4'b0000;
      case (size_i)
         SZ_BYTE: byte_en = 4'b0001 << addr_lo_i;
         SZ_HALF: byte_en = addr_lo_i[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: byte_en = 4'b1111;
         default: byte_en = 4'b0000;
      endcase
   end

   // Each lane picks its source byte from wdata according to the access width.
   genvar gi;
   generate
      for (gi = 0; gi < N_LANES; gi++) begin : g_lane
         logic [7:0] src_byte;
         assign src_byte = (size_i == SZ_BYTE) ? wdata_i[7:0] :
                           (size_i == SZ_HALF) ? wdata_i[BYTE_W*(gi%2) +: BYTE_W] :
                                                 wdata_i[BYTE_W*gi +: BYTE_W];
         assign merge_o[BYTE_W*gi +: BYTE_W] = byte_en[gi] ? src_byte : word_i[BYTE_W*gi +: BYTE_W];
      end
   endgenerate

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory stage: latches one load/store, waits LATENCY cycles, then performs the access
// on a local word array and pulses done_o (with err_o for rejected requests).
module data_mem_ctrl
   import data_mem_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int DEPTH   = 128,
   parameter int LATENCY = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic              re_i,
   input  logic              we_i,
   input  logic [1:0]        size_i,
   input  logic              uns_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int AL_W  = IDX_W + 2;
   localparam int CNT_W = ($clog2(LATENCY) > 0) ? $clog2(LATENCY) : 1;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [AL_W-1:0]    addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [1:0]         size_q, size_d;
   logic               uns_q, uns_d;
   logic               re_q, re_d;
   logic               we_q, we_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic [DATA_W-1:0]  mem_q [DEPTH];
   logic [IDX_W-1:0]   word_idx;
   logic [DATA_W-1:0]  rd_word;
   logic [DATA_W-1:0]  load_val;
   logic [DATA_W-1:0]  merge_val;
   logic               misalign;
   logic               acc_err;
   logic               mem_we;

   // Address bits above the array index alias onto the same words.
   logic unused_addr;
   assign unused_addr = ^addr_i[ADDR_W-1:AL_W];

   assign word_idx = addr_q[AL_W-1:2];
   assign rd_word  = mem_q[word_idx];
   assign acc_err  = (re_q && we_q) || (size_q == SZ_ILL) || misalign;

   dmem_lane u_lane (
      .addr_lo_i  (addr_q[1:0]),
      .size_i     (size_q),
      .uns_i      (uns_q),
      .word_i     (rd_word),
      .wdata_i    (wdata_q),
      .load_o     (load_val),
      .merge_o    (merge_val),
      .misalign_o (misalign)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      uns_d   = uns_q;
      re_d    = re_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      mem_we  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (req_i && (re_i || we_i)) begin
               addr_d  = addr_i[AL_W-1:0];
               wdata_d = wdata_i;
               size_d  = size_i;
               uns_d   = uns_i;
               re_d    = re_i;
               we_d    = we_i;
               cnt_d   = CNT_W'(LATENCY - 1);
               busy_d  = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
               done_d  = 1'b1;
               err_d   = acc_err;
               if (!acc_err) begin
                  if (re_q) rdata_d = load_val;
                  mem_we = we_q;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESP: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= SZ_BYTE;
         uns_q   <= 1'b0;
         re_q    <= 1'b0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         re_q    <= re_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Contents survive reset; writes only ever come from a live WAIT state.
   always_ff @(posedge clk_i) begin
      if (mem_we) mem_q[word_idx] <= merge_val;
   end

   assign rdata_o = rdata_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;
   assign err_o   = err_q;

endmodule
